// File: rtl/pulse_handshake_initiator_if.sv
// Signal bundle between the event-pulse initiator and the logic around it.
// CNT_WIDTH must match the CNT_WIDTH of the initiator it is connected to.
interface pulse_handshake_initiator_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 pulse_in;
  logic                 ack_async;
  logic                 clear_overflow;
  logic                 req_out;
  logic [CNT_WIDTH-1:0] pending;
  logic                 busy;
  logic                 done_pulse;
  logic                 overflow;

  modport master (
    input  pulse_in,
    input  ack_async,
    input  clear_overflow,
    output req_out,
    output pending,
    output busy,
    output done_pulse,
    output overflow
  );

  modport slave (
    output pulse_in,
    output ack_async,
    output clear_overflow,
    input  req_out,
    input  pending,
    input  busy,
    input  done_pulse,
    input  overflow
  );
endinterface

// File: rtl/pulse_handshake_initiator.sv
// Source-domain end of a four-phase req/ack handshake that carries counted event
// pulses into another clock domain, one event per handshake.
module pulse_handshake_initiator #(
  parameter int CNT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  pulse_handshake_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } stateT;

  localparam logic [CNT_WIDTH-1:0] PENDING_MAX = '1;

  stateT                  state;
  stateT                  stateNext;
  logic [SYNC_STAGES-1:0] ackChain;
  logic                   ackSync;
  logic [CNT_WIDTH-1:0]   pendingQ;
  logic [CNT_WIDTH-1:0]   pendingNext;
  logic                   dec;
  logic                   dropEvent;
  logic                   doneNext;
  logic                   reqQ;
  logic                   busyQ;
  logic                   doneQ;
  logic                   overflowQ;

  // The far side's ack is a raw level from another domain; only the last stage is trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ackChain <= '0;
    end else begin
      ackChain <= {ackChain[SYNC_STAGES-2:0], bus.ack_async};
    end
  end

  assign ackSync = ackChain[SYNC_STAGES-1];

  // IDLE refuses to launch while the ack is still high, so a far side left over
  // from before our reset gets to finish its own release first.
  always_comb begin
    stateNext = state;
    dec       = 1'b0;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        if ((pendingQ != '0) && !ackSync) begin
          stateNext = REQ;
          dec       = 1'b1;
        end
      end
      REQ: begin
        if (ackSync) begin
          stateNext = RELEASE;
        end
      end
      RELEASE: begin
        if (!ackSync) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    dropEvent   = bus.pulse_in && !dec && (pendingQ == PENDING_MAX);
    pendingNext = pendingQ;
    if (bus.pulse_in && !dec && !dropEvent) begin
      pendingNext = pendingQ + CNT_WIDTH'(1);
    end else if (!bus.pulse_in && dec) begin
      pendingNext = pendingQ - CNT_WIDTH'(1);
    end
  end

  // Outputs are registered from the next state so req_out tracks REQ exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      reqQ      <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
      pendingQ  <= '0;
      overflowQ <= 1'b0;
    end else begin
      state    <= stateNext;
      reqQ     <= (stateNext == REQ);
      busyQ    <= (stateNext != IDLE);
      doneQ    <= doneNext;
      pendingQ <= pendingNext;
      if (dropEvent) begin
        overflowQ <= 1'b1;
      end else if (bus.clear_overflow) begin
        overflowQ <= 1'b0;
      end
    end
  end

  assign bus.req_out    = reqQ;
  assign bus.pending    = pendingQ;
  assign bus.busy       = busyQ;
  assign bus.done_pulse = doneQ;
  assign bus.overflow   = overflowQ;

endmodule
